// File: rtl/i2s_to_wb_tx_stereo_if.sv
// ---------------------------------------------------------------------------
// i2s_to_wb_tx_stereo_if
//
// Purpose: prefetches L/R audio sample pairs from a circular word buffer in
// system memory over a Wishbone master port. It queues them in a small FIFO
// for the I2S transmitter. The transmitter pops pairs with an asynchronous
// acknowledge.
//
// Ports:
//   i2s_clk_i, i2s_rst_i          single clock, synchronous active-low reset
//   i2s_enable, mono_mode         run enable, one fetch per frame (L copied to R)
//   i2s_ws_edge, i2s_ws_i         async WS edge strobe / level (underrun detect)
//   fifo_ack                      async pop request (rising edge pops one pair)
//   fifo_ready, fifo_*_data       head pair valid / head pair (0 when empty)
//   dma_base_i, dma_buffer_size   buffer byte base, buffer length in words
//   dma_rd_pointer_i/_we/_o       pointer load (byte offset) / current fetch addr
//   wbm_*                         Wishbone read master
//   dma_overflow_error, dma_bus_error, underrun_error   sticky error flags
//
// FSM states:
//   state      | meaning
//   ST_IDLE    | apply pointer loads, flush when disabled, start when FIFO not full
//   ST_FETCH_L | bus read of the left (or mono) word
//   ST_FETCH_R | bus read of the right word
//   ST_PUSH    | write the captured pair into the FIFO
// ---------------------------------------------------------------------------
module i2s_to_wb_tx_stereo_if #(
  parameter int DMA_BUFFER_MAX_WIDTH = 12,
  parameter int FIFO_DEPTH_LOG2      = 2,
  parameter int SAMPLE_WIDTH         = 24
) (
  input  logic                            i2s_clk_i,
  input  logic                            i2s_rst_i,
  input  logic                            i2s_enable,
  input  logic                            mono_mode,
  input  logic                            i2s_ws_edge,
  input  logic                            i2s_ws_i,
  input  logic                            fifo_ack,
  output logic                            fifo_ready,
  output logic [31:0]                     fifo_left_data,
  output logic [31:0]                     fifo_right_data,
  input  logic [31:0]                     dma_base_i,
  input  logic [31:0]                     dma_rd_pointer_i,
  input  logic                            dma_rd_pointer_we,
  output logic [31:0]                     dma_rd_pointer_o,
  input  logic [DMA_BUFFER_MAX_WIDTH-1:0] dma_buffer_size,
  output logic [31:0]                     wbm_addr_o,
  input  logic [31:0]                     wbm_data_i,
  output logic [3:0]                      wbm_sel_o,
  output logic                            wbm_we_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic                            wbm_rty_i,
  output logic                            dma_overflow_error,
  output logic                            dma_bus_error,
  output logic                            underrun_error
);

  localparam int W = DMA_BUFFER_MAX_WIDTH;
  localparam int L = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [L:0] DEPTH_C = (L + 1)'(DEPTH);
  localparam logic [31:0] SAMPLE_MASK = ~((32'd1 << (32 - SAMPLE_WIDTH)) - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH_L = 2'd1,
    ST_FETCH_R = 2'd2,
    ST_PUSH    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        gap_q, gap_d;
  logic [W-1:0] index_q, index_d;
  logic        pend_q, pend_d;
  logic [W-1:0] pend_idx_q, pend_idx_d;
  logic [31:0] left_q, left_d;
  logic [31:0] right_q, right_d;

  logic [31:0] mem_l_q [DEPTH];
  logic [31:0] mem_l_d [DEPTH];
  logic [31:0] mem_r_q [DEPTH];
  logic [31:0] mem_r_d [DEPTH];
  logic [L-1:0] wr_ptr_q, wr_ptr_d;
  logic [L-1:0] rd_ptr_q, rd_ptr_d;
  logic [L:0]   count_q, count_d;

  logic [1:0]  ws_edge_sync_q, ws_edge_sync_d;
  logic [1:0]  ws_sync_q, ws_sync_d;
  // bit 2 holds the previous synchronised level for rising-edge detection
  logic [2:0]  ack_sync_q, ack_sync_d;

  logic        ovf_q, ovf_d;
  logic        bus_err_q, bus_err_d;
  logic        underrun_q, underrun_d;

  logic [W-1:0] eff_size;
  logic [W:0]   index_inc;
  logic [W-1:0] index_next;
  logic         fifo_empty, fifo_full;
  logic         fetching, rsp_ack, rsp_err, rsp_rty;
  logic         pop_pulse, do_pop, do_push, do_flush;
  logic [31:0]  sample;
  logic         unused_ptr_bits;

  assign unused_ptr_bits = ^{dma_rd_pointer_i[31:W+2], dma_rd_pointer_i[1:0]};

  always_comb begin
    eff_size   = (dma_buffer_size == '0) ? {{(W-1){1'b0}}, 1'b1} : dma_buffer_size;
    index_inc  = {1'b0, index_q} + {{W{1'b0}}, 1'b1};
    // >= rather than == so a buffer shrunk below the index still wraps cleanly
    index_next = (index_inc >= {1'b0, eff_size}) ? '0 : index_inc[W-1:0];
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    sample     = wbm_data_i & SAMPLE_MASK;
    pop_pulse  = ack_sync_q[1] & ~ack_sync_q[2];
    do_pop     = pop_pulse & ~fifo_empty;
    fetching   = ((state_q == ST_FETCH_L) || (state_q == ST_FETCH_R)) && !gap_q;
    // responses are only honoured while a request is actually on the bus
    rsp_err    = fetching & wbm_err_i;
    rsp_rty    = fetching & ~wbm_err_i & wbm_rty_i;
    rsp_ack    = fetching & ~wbm_err_i & ~wbm_rty_i & wbm_ack_i;
  end

  // fetch FSM, pointer and pair capture
  always_comb begin
    state_d    = state_q;
    gap_d      = 1'b0;
    index_d    = index_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    left_d     = left_q;
    right_d    = right_q;
    ovf_d      = ovf_q;
    bus_err_d  = bus_err_q;
    do_push    = 1'b0;
    do_flush   = 1'b0;

    if (dma_rd_pointer_we) begin
      pend_d     = 1'b1;
      pend_idx_d = dma_rd_pointer_i[W+1:2];
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_d) begin
          pend_d = 1'b0;
          if (pend_idx_d >= eff_size) begin
            index_d = '0;
            ovf_d   = 1'b1;
          end else begin
            index_d = pend_idx_d;
          end
        end
        if (!i2s_enable) begin
          do_flush = 1'b1;
        end else if (!fifo_full) begin
          state_d = ST_FETCH_L;
        end
      end
      ST_FETCH_L: begin
        if (rsp_err) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (rsp_rty) begin
          gap_d = 1'b1;
        end else if (rsp_ack) begin
          left_d  = sample;
          index_d = index_next;
          if (mono_mode) begin
            right_d = sample;
            state_d = ST_PUSH;
          end else if (!i2s_enable) begin
            // bus cycle finished; partial pair is dropped since the FIFO flushes
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH_R;
          end
        end
      end
      ST_FETCH_R: begin
        if (rsp_err) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (rsp_rty) begin
          gap_d = 1'b1;
        end else if (rsp_ack) begin
          right_d = sample;
          index_d = index_next;
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        do_push = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // pair FIFO
  always_comb begin
    mem_l_d  = mem_l_q;
    mem_r_d  = mem_r_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_l_d[wr_ptr_q] = left_q;
        mem_r_d[wr_ptr_q] = right_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // synchronisers and underrun detect
  always_comb begin
    ws_edge_sync_d = {ws_edge_sync_q[0], i2s_ws_edge};
    ws_sync_d      = {ws_sync_q[0], i2s_ws_i};
    ack_sync_d     = {ack_sync_q[1], ack_sync_q[0], fifo_ack};
    underrun_d     = underrun_q |
                     (ws_edge_sync_q[1] & ~ws_sync_q[1] & i2s_enable & fifo_empty);
  end

  always_ff @(posedge i2s_clk_i) begin
    if (!i2s_rst_i) begin
      state_q        <= ST_IDLE;
      gap_q          <= 1'b0;
      index_q        <= '0;
      pend_q         <= 1'b0;
      pend_idx_q     <= '0;
      left_q         <= '0;
      right_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_l_q[i] <= '0;
        mem_r_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ws_edge_sync_q <= '0;
      ws_sync_q      <= '0;
      ack_sync_q     <= '0;
      ovf_q          <= 1'b0;
      bus_err_q      <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      index_q        <= index_d;
      pend_q         <= pend_d;
      pend_idx_q     <= pend_idx_d;
      left_q         <= left_d;
      right_q        <= right_d;
      mem_l_q        <= mem_l_d;
      mem_r_q        <= mem_r_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ws_edge_sync_q <= ws_edge_sync_d;
      ws_sync_q      <= ws_sync_d;
      ack_sync_q     <= ack_sync_d;
      ovf_q          <= ovf_d;
      bus_err_q      <= bus_err_d;
      underrun_q     <= underrun_d;
    end
  end

  // cyc/stb are gated by reset so an open cycle is dropped without waiting for the edge
  assign wbm_cyc_o          = fetching & i2s_rst_i;
  assign wbm_stb_o          = fetching & i2s_rst_i;
  assign wbm_sel_o          = 4'hF;
  assign wbm_we_o           = 1'b0;
  assign dma_rd_pointer_o   = dma_base_i + {{(30-W){1'b0}}, index_q, 2'b00};
  assign wbm_addr_o         = dma_rd_pointer_o;
  assign fifo_ready         = i2s_enable & ~fifo_empty;
  assign fifo_left_data     = fifo_empty ? 32'd0 : mem_l_q[rd_ptr_q];
  assign fifo_right_data    = fifo_empty ? 32'd0 : mem_r_q[rd_ptr_q];
  assign dma_overflow_error = ovf_q;
  assign dma_bus_error      = bus_err_q;
  assign underrun_error     = underrun_q;

endmodule

// File: tb/tb_i2s_to_wb_tx_stereo_if.sv
module tb_i2s_to_wb_tx_stereo_if;
  localparam int SW = 24;

  logic        i2s_clk_i = 1'b0;
  logic        i2s_rst_i;
  logic        i2s_enable, mono_mode, i2s_ws_edge, i2s_ws_i, fifo_ack;
  logic        fifo_ready;
  logic [31:0] fifo_left_data, fifo_right_data;
  logic [31:0] dma_base_i, dma_rd_pointer_i, dma_rd_pointer_o;
  logic        dma_rd_pointer_we;
  logic [11:0] dma_buffer_size;
  logic [31:0] wbm_addr_o, wbm_data_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic        dma_overflow_error, dma_bus_error, underrun_error;

  i2s_to_wb_tx_stereo_if #(.DMA_BUFFER_MAX_WIDTH(12), .FIFO_DEPTH_LOG2(2), .SAMPLE_WIDTH(SW)) dut (
    .i2s_clk_i(i2s_clk_i), .i2s_rst_i(i2s_rst_i), .i2s_enable(i2s_enable), .mono_mode(mono_mode),
    .i2s_ws_edge(i2s_ws_edge), .i2s_ws_i(i2s_ws_i), .fifo_ack(fifo_ack), .fifo_ready(fifo_ready),
    .fifo_left_data(fifo_left_data), .fifo_right_data(fifo_right_data), .dma_base_i(dma_base_i),
    .dma_rd_pointer_i(dma_rd_pointer_i), .dma_rd_pointer_we(dma_rd_pointer_we),
    .dma_rd_pointer_o(dma_rd_pointer_o), .dma_buffer_size(dma_buffer_size), .wbm_addr_o(wbm_addr_o),
    .wbm_data_i(wbm_data_i), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .dma_overflow_error(dma_overflow_error), .dma_bus_error(dma_bus_error),
    .underrun_error(underrun_error));

  always #5 i2s_clk_i = ~i2s_clk_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16];
  logic [31:0] exp_l [$];
  logic [31:0] exp_r [$];
  logic [31:0] exp_base = 32'h0;
  int          exp_i0 = 0, exp_size = 1, nacks = 0;
  bit          addr_chk_en = 0, stall = 0, consume_en = 0, resp_active = 0;
  int          fault = 0, rty_stage = 0, wait_cnt = 0, rty_count = 0;
  logic [31:0] rty_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] smp(input logic [31:0] w);
    return (w >> (32 - SW)) << (32 - SW);
  endfunction

  // Wishbone slave: random wait states, optional stall / one-shot rty or err
  initial begin
    wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; wbm_data_i = 0;
    forever begin
      @(negedge i2s_clk_i);
      if (!resp_active && rty_stage == 2) begin
        chk("rty_reissue_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        chk("rty_reissue_addr", wbm_addr_o, rty_addr);
        rty_stage = 0;
      end
      if (resp_active) begin
        wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
        resp_active = 0;
        wait_cnt = $urandom_range(0, 2);
        if (rty_stage == 1) begin
          chk("rty_gap_cyc", {31'd0, wbm_cyc_o}, 32'd0);
          rty_stage = 2;
        end
      end else if (wbm_cyc_o && wbm_stb_o && !stall) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          resp_active = 1;
          if (fault == 1) begin
            wbm_rty_i = 1; fault = 0; rty_stage = 1; rty_addr = wbm_addr_o; rty_count++;
          end else if (fault == 2) begin
            wbm_err_i = 1; fault = 0;
          end else begin
            wbm_data_i = mem[((wbm_addr_o - exp_base) >> 2) & 32'hF];
            wbm_ack_i = 1;
            if (addr_chk_en) begin
              chk("fetch_addr", wbm_addr_o, exp_base + 32'(4 * ((exp_i0 + nacks) % exp_size)));
              nacks++;
            end
          end
        end
      end else begin
        wait_cnt = $urandom_range(0, 2);
      end
    end
  end

  // consumer / scoreboard monitor
  initial begin
    fifo_ack = 0;
    forever begin
      @(negedge i2s_clk_i);
      if (consume_en && fifo_ready && exp_l.size() > 0) begin
        chk("pair_left", fifo_left_data, exp_l[0]);
        chk("pair_right", fifo_right_data, exp_r[0]);
        void'(exp_l.pop_front());
        void'(exp_r.pop_front());
        fifo_ack = 1;
        repeat (3) @(negedge i2s_clk_i);
        fifo_ack = 0;
        repeat (3) @(negedge i2s_clk_i);
      end
    end
  end

  task automatic load_ptr(input logic [31:0] v);
    dma_rd_pointer_i = v; dma_rd_pointer_we = 1;
    @(negedge i2s_clk_i);
    dma_rd_pointer_we = 0;
  endtask

  task automatic run_scen(input logic [31:0] base, input int size, input int i0,
                          input bit mono, input int npairs, input int flt);
    int eff, cnt;
    i2s_enable = 0; consume_en = 0; addr_chk_en = 0;
    repeat (12) @(negedge i2s_clk_i);
    eff = (size == 0) ? 1 : size;
    dma_base_i = base; dma_buffer_size = 12'(size); mono_mode = mono;
    load_ptr(32'(i0 * 4));
    exp_base = base; exp_i0 = i0; exp_size = eff; nacks = 0; addr_chk_en = 1; fault = flt;
    for (int k = 0; k < npairs; k++) begin
      if (mono) begin
        exp_l.push_back(smp(mem[(i0 + k) % eff]));
        exp_r.push_back(smp(mem[(i0 + k) % eff]));
      end else begin
        exp_l.push_back(smp(mem[(i0 + 2 * k) % eff]));
        exp_r.push_back(smp(mem[(i0 + 2 * k + 1) % eff]));
      end
    end
    consume_en = 1; i2s_enable = 1;
    cnt = 0;
    while (exp_l.size() > 0 && cnt < 3000) begin
      @(negedge i2s_clk_i);
      cnt++;
    end
    if (exp_l.size() > 0) begin
      checks++; failures++;
      $display("FAIL scen_timeout actual=%0d pairs left required=0", exp_l.size());
      exp_l.delete(); exp_r.delete();
    end
    consume_en = 0; i2s_enable = 0;
    repeat (12) @(negedge i2s_clk_i);
    addr_chk_en = 0;
  endtask

  initial begin
    i2s_rst_i = 0; i2s_enable = 0; mono_mode = 0; i2s_ws_edge = 0; i2s_ws_i = 0;
    dma_base_i = 32'h1000; dma_rd_pointer_i = 0; dma_rd_pointer_we = 0; dma_buffer_size = 12'd8;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (3) @(negedge i2s_clk_i);
    chk("rst_ready", {31'd0, fifo_ready}, 32'd0);
    chk("rst_left", fifo_left_data, 32'd0);
    chk("rst_right", fifo_right_data, 32'd0);
    chk("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("rst_errors", {29'd0, dma_overflow_error, dma_bus_error, underrun_error}, 32'd0);
    chk("rst_pointer", dma_rd_pointer_o, 32'h1000);
    chk("sel_we", {27'd0, wbm_sel_o, wbm_we_o}, 32'h1E);
    i2s_rst_i = 1;

    mem[0] = 32'hAABBCCDD; mem[1] = 32'h11223344;
    run_scen(32'h1000, 8, 0, 0, 2, 0);
    chk("stereo_head_model", smp(32'hAABBCCDD), 32'hAABBCC00);
    run_scen(32'h1000, 3, 2, 0, 3, 0);
    mem[0] = 32'h12345678;
    run_scen(32'h1000, 8, 0, 1, 3, 0);

    for (int it = 0; it < 6; it++) begin
      int sz, i0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      sz = $urandom_range(0, 16);
      i0 = $urandom_range(0, (sz == 0) ? 0 : sz - 1);
      run_scen($urandom & 32'hFFFF_FFFC, sz, i0, bit'($urandom_range(0, 1)), $urandom_range(3, 6), 0);
    end
    chk("no_bus_err_yet", {31'd0, dma_bus_error}, 32'd0);

    run_scen(32'h3000, 5, 1, 0, 3, 1);
    chk("rty_seen", rty_count, 32'd1);
    run_scen(32'h4000, 6, 3, 0, 3, 2);
    chk("bus_err_set", {31'd0, dma_bus_error}, 32'd1);

    chk("no_ovf_yet", {31'd0, dma_overflow_error}, 32'd0);
    dma_base_i = 32'h5000; dma_buffer_size = 12'd8;
    load_ptr(32'h40);
    @(negedge i2s_clk_i);
    chk("ovf_set", {31'd0, dma_overflow_error}, 32'd1);
    chk("ovf_ptr_base", dma_rd_pointer_o, 32'h5000);

    // deferred pointer load while a fetch is open
    dma_base_i = 32'h2000; mono_mode = 0;
    load_ptr(32'h0);
    stall = 1; i2s_enable = 1;
    repeat (4) @(negedge i2s_clk_i);
    chk("stall_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    load_ptr(32'h8);
    repeat (3) @(negedge i2s_clk_i);
    chk("defer_ptr_held", dma_rd_pointer_o, 32'h2000);
    i2s_enable = 0; stall = 0;
    repeat (10) @(negedge i2s_clk_i);
    chk("defer_ptr_applied", dma_rd_pointer_o, 32'h2008);

    // underrun: FIFO empty, slave stalled
    stall = 1; i2s_enable = 1;
    repeat (4) @(negedge i2s_clk_i);
    i2s_ws_i = 1; i2s_ws_edge = 1;
    @(negedge i2s_clk_i);
    i2s_ws_edge = 0;
    repeat (5) @(negedge i2s_clk_i);
    chk("underrun_right_slot", {31'd0, underrun_error}, 32'd0);
    i2s_ws_i = 0; i2s_ws_edge = 1;
    @(negedge i2s_clk_i);
    i2s_ws_edge = 0;
    chk("underrun_early", {31'd0, underrun_error}, 32'd0);
    repeat (3) @(negedge i2s_clk_i);
    chk("underrun_set", {31'd0, underrun_error}, 32'd1);
    chk("sticky_bus_err", {31'd0, dma_bus_error}, 32'd1);

    // reset in the middle of a stalled fetch
    chk("mid_cyc_open", {31'd0, wbm_cyc_o}, 32'd1);
    i2s_rst_i = 0;
    @(negedge i2s_clk_i);
    chk("mid_rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, fifo_ready}, 32'd0);
    chk("mid_rst_data", fifo_left_data | fifo_right_data, 32'd0);
    chk("mid_rst_errors", {29'd0, dma_overflow_error, dma_bus_error, underrun_error}, 32'd0);
    chk("mid_rst_ptr", dma_rd_pointer_o, 32'h2000);
    i2s_enable = 0; stall = 0;
    @(negedge i2s_clk_i);
    i2s_rst_i = 1;
    repeat (2) @(negedge i2s_clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
